mips_cpu_muldiv: RTL and testbench



---
 rtl/mips_cpu_pkg.sv | 23 ++
 rtl/mips_cpu_muldiv_divstep.sv | 21 ++
 rtl/mips_cpu_muldiv.sv | 125 ++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared op/state encodings and constants for the MIPS32 multiply/divide unit.
package mips_cpu_pkg;

    localparam int MULDIV_ITER = 32;
    localparam logic [MULDIV_ITER-1:0] DIV0_LO = '1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_divstep.sv
// mips_cpu_muldiv_divstep: one combinational restoring-division step (next remainder and quotient bit).
module mips_cpu_muldiv_divstep
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_nx,
    output logic             qbit
);

    logic [WIDTH:0] diff;

    // the remainder stays below the divisor, so the shifted partial fits in WIDTH+1 bits
    assign diff   = {rem, bit_in} - {1'b0, divisor};
    assign qbit   = ~diff[WIDTH];
    assign rem_nx = qbit ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], bit_in};

endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MULT/MULTU/DIV/DIVU unit holding HI/LO, plus MTHI/MTLO.
// Define MIPS_CPU_MULDIV_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand, prod;
    logic [WIDTH-1:0]   mpl, rem, dq, dvsr, rem_nx, mag_a, mag_b, quo, rmd;
    logic               sgn, sa, sb, neg_q, neg_r, div0, is_div, qbit, last, early;

    assign sgn   = op == OP_MULT || op == OP_DIV;
    assign sa    = sgn & opA[WIDTH-1];
    assign sb    = sgn & opB[WIDTH-1];
    assign mag_a = sa ? -opA : opA;
    assign mag_b = sb ? -opB : opB;
    assign last  = cnt == CW'(WIDTH-1);
    assign busy  = state != IDLE;

`ifdef MIPS_CPU_MULDIV_EARLY_TERM_EN
    assign early = mpl[WIDTH-1:1] == '0;
`else
    assign early = 1'b0;
`endif

    // divide-by-zero leaves the magnitude of opA in rem, so the normal sign fix restores opA for hi
    assign prod = neg_q ? -acc : acc;
    assign quo  = div0 ? WIDTH'(DIV0_LO) : neg_q ? -dq : dq;
    assign rmd  = neg_r ? -rem : rem;

    mips_cpu_muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem    (rem),
        .divisor(dvsr),
        .bit_in (dq[WIDTH-1]),
        .rem_nx (rem_nx),
        .qbit   (qbit)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start ? IDLE
                              : (op == OP_MULT || op == OP_MULTU) ? MUL
                              : (op == OP_DIV || op == OP_DIVU) ? DIV : IDLE;
            MUL:     state_nx = last || early ? FIX : MUL;
            DIV:     state_nx = last ? FIX : DIV;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mpl    <= '0;
            rem    <= '0;
            dq     <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            is_div <= 1'b0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: if (start) begin
                    hi     <= op == OP_MTHI ? opA : hi;
                    lo     <= op == OP_MTLO ? opA : lo;
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, mag_a};
                    mpl    <= mag_b;
                    rem    <= '0;
                    dq     <= mag_a;
                    dvsr   <= mag_b;
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    div0   <= opB == '0;
                    is_div <= op == OP_DIV || op == OP_DIVU;
                    cnt    <= '0;
                end
                MUL: begin
                    acc   <= acc + (mpl[0] ? mcand : '0);
                    mcand <= mcand << 1;
                    mpl   <= mpl >> 1;
                    cnt   <= cnt + CW'(1);
                end
                DIV: begin
                    rem <= rem_nx;
                    dq  <= {dq[WIDTH-2:0], qbit};
                    cnt <= cnt + CW'(1);
                end
                FIX: {hi, lo} <= is_div ? {rmd, quo} : prod;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed scoreboard bench; stimulus pushes expected HI:LO, a negedge monitor pops on done.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    muldiv_op_t  op = OP_MULT;
    logic [31:0] opA = '0, opB = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0, fails = 0;
    logic [63:0] q_exp[$];
    string       q_name[$];

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every done pulse, checks hold of hi/lo while busy and latency
    initial begin
        int          ncyc = 0, t0 = 0;
        logic        pbusy = 1'b0;
        logic [63:0] phl = '0, e;
        string       nm;
        forever begin
            @(negedge clk);
            ncyc++;
            if (busy && !pbusy) t0 = ncyc;
            if (busy && pbusy) chk("hold", {hi, lo}, phl);
            if (done) begin
                if (q_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    e  = q_exp.pop_front();
                    nm = q_name.pop_front();
                    chk(nm, {hi, lo}, e);
`ifndef MIPS_CPU_MULDIV_EARLY_TERM_EN
                    chk({nm, "_latency"}, 64'(ncyc - t0), 64'd33);
`endif
                end
            end
            pbusy = busy;
            phl   = {hi, lo};
        end
    end

    task automatic go(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({nm, "_timeout"}, 64'(n), 64'd0);
    endtask

    task automatic run(input string nm, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
        q_exp.push_back({ehi, elo});
        q_name.push_back(nm);
        go(o, a, b);
        wait_done(nm);
    endtask

    initial begin
        #1;
        chk("reset_state", {busy, done, hi, lo}, 66'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        go(OP_MTHI, 32'h12345678, 32'h0);
        chk("mthi", {32'(busy), hi}, {32'd0, 32'h12345678});
        go(OP_MTLO, 32'hCAFEBABE, 32'h0);
        chk("mtlo", {32'(busy), lo}, {32'd0, 32'hCAFEBABE});
        chk("mtlo_hi_kept", {32'd0, hi}, {32'd0, 32'h12345678});
        go(muldiv_op_t'(3'd6), 32'hDEAD, 32'h1);
        @(negedge clk);
        chk("reserved_ignored", {31'd0, busy, hi, lo}, {32'd0, 32'h12345678, 32'hCAFEBABE});

        run("mult_neg", OP_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);
        run("mult_min_sq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        run("mult_zero", OP_MULT, 32'h3, 32'h0, 32'h0, 32'h0);
        run("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_negb", OP_DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
        run("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run("div_by0_neg", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // starts while busy and during FIX must be dropped
        q_exp.push_back({32'd0, 32'd15});
        q_name.push_back("mult_3x5");
        go(OP_MULT, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        op = OP_DIV; opA = 32'd100; opB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        op = OP_DIV; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_at_e33", 64'(done), 64'd1);
        @(negedge clk);
        chk("fix_start_ignored", 64'(busy), 64'd0);

        // asynchronous reset mid-operation discards the result
        go(OP_MULT, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_idle", {31'd0, busy, hi, lo}, 96'd0);

        // back-to-back: next start issued in the done cycle
        q_exp.push_back({32'd1, 32'd0});
        q_name.push_back("b2b_first");
        go(OP_MULTU, 32'h10000, 32'h10000);
        wait_done("b2b_first");
        q_exp.push_back({32'd2, 32'd14});
        q_name.push_back("b2b_second");
        op = OP_DIVU; opA = 32'd100; opB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted", {31'd0, busy, hi, lo}, {32'd1, 32'd1, 32'd0});
        wait_done("b2b_second");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
